// File: rtl/mmio_uart_pkg.sv
// Shared types and register-map constants for the memory-mapped UART transmitter.
// Offsets are relative to the start of the 16-byte register window.
package mmio_uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_e;

    localparam logic [3:0] TXDATA_OFS = 4'h4;
    localparam logic [3:0] STATUS_OFS = 4'h8;

    // STATUS register bit positions
    localparam int STAT_BUSY    = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_EMPTY   = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 4;

    localparam int UART_DATA_BITS = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular-buffer FIFO with first-word-fall-through read data.
// Push while full and pop while empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       srst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW:0]      count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count_reg == FULL_COUNT);
    assign empty    = (count_reg == '0);
    assign count    = count_reg;
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr_reg];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (srst) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: byte stores to TXDATA are queued and sent 8N1,
// STATUS exposes busy/full/empty/overflow/count for firmware polling.
module mmio_uart_tx
    import mmio_uart_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] BASE_ADDR  = 'h0001_0040,
    parameter int               CLK_DIV    = 868,
    parameter int               FIFO_DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             we_i,
    input  logic             one_byte_i,
    output logic             hit_o,
    output logic [WIDTH-1:0] rdata_o,
    output logic             tx_o,
    output logic             busy_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);

    generate
        if (CLK_DIV < 2) begin : g_bad_clk_div
            $error("mmio_uart_tx: CLK_DIV must be at least 2");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("mmio_uart_tx: FIFO_DEPTH must be a power of two, at least 2");
        end
        if (WIDTH < 8) begin : g_bad_width
            $error("mmio_uart_tx: WIDTH must be at least 8");
        end
    endgenerate

    // Address decode
    logic [WIDTH-1:0] ofs;
    logic             is_txdata;
    logic             is_status;
    logic             push_req;
    logic             unused_wdata;

    assign ofs          = addr_i - BASE_ADDR;
    assign hit_o        = (addr_i >= BASE_ADDR) && (ofs[WIDTH-1:4] == '0);
    assign is_txdata    = hit_o && (ofs[3:0] == TXDATA_OFS);
    assign is_status    = hit_o && (ofs[3:2] == STATUS_OFS[3:2]);
    assign push_req     = we_i && one_byte_i && is_txdata;
    assign unused_wdata = ^wdata_i[WIDTH-1:8];

    // FIFO
    logic          fifo_pop;
    logic [7:0]    fifo_data;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_i),
        .srst      (rst_i),
        .push      (push_req),
        .push_data (wdata_i[7:0]),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Overflow is sticky until any write lands on STATUS.
    logic overflow_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            overflow_reg <= 1'b0;
        end else if (we_i && is_status) begin
            overflow_reg <= 1'b0;
        end else if (push_req && fifo_full) begin
            overflow_reg <= 1'b1;
        end
    end

    // Serializer
    uart_state_e   state_reg, state_next;
    logic [BW-1:0] baud_reg, baud_next;
    logic [2:0]    bit_reg, bit_next;
    logic [7:0]    shift_reg, shift_next;
    logic          tx_reg, tx_next;
    logic          baud_end;

    assign baud_end = (baud_reg == BAUD_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            baud_reg  <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            tx_reg    <= 1'b1;
        end else begin
            state_reg <= state_next;
            baud_reg  <= baud_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            tx_reg    <= tx_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        baud_next  = baud_reg + 1'b1;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        fifo_pop   = 1'b0;
        tx_next    = 1'b1;

        unique case (state_reg)
            IDLE: begin
                baud_next = '0;
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    shift_next = fifo_data;
                    state_next = START;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_next  = '0;
                    bit_next   = '0;
                    state_next = DATA;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_next  = '0;
                    shift_next = shift_reg >> 1;
                    if (bit_reg == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_next = bit_reg + 1'b1;
                    end
                end
            end
            STOP: begin
                // Chain straight into the next start bit so frames stay contiguous.
                if (baud_end) begin
                    baud_next = '0;
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        shift_next = fifo_data;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                baud_next  = '0;
            end
        endcase

        unique case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
    end

    assign tx_o   = tx_reg;
    assign busy_o = (state_reg != IDLE) || !fifo_empty;

    // STATUS read mux; count field saturates at 15 for deep FIFOs.
    logic [3:0] count_sat;
    logic [7:0] status;

    generate
        if (CW > 4) begin : g_count_sat
            assign count_sat = (fifo_count > CW'(15)) ? 4'hF : fifo_count[3:0];
        end else begin : g_count_ext
            assign count_sat = 4'(fifo_count);
        end
    endgenerate

    always_comb begin
        status                              = '0;
        status[STAT_BUSY]                   = busy_o;
        status[STAT_FULL]                   = fifo_full;
        status[STAT_EMPTY]                  = fifo_empty;
        status[STAT_OVF]                    = overflow_reg;
        status[STAT_CNT_LSB+3:STAT_CNT_LSB] = count_sat;
    end

    assign rdata_o = is_status ? WIDTH'(status) : '0;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: a frame-level model predicts accepted bytes,
// frame start cycles and STATUS; a serial monitor decodes tx_o and compares.
module tb_mmio_uart_tx;

    localparam int          CLK_DIV = 4;
    localparam int          DEPTH   = 4;
    localparam int          FRAME   = 10 * CLK_DIV;
    localparam logic [31:0] BASE    = 32'h0001_0040;
    localparam logic [31:0] TXD     = BASE + 32'h4;
    localparam logic [31:0] STAT    = BASE + 32'h8;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic        we_i = 1'b0;
    logic        one_byte_i = 1'b0;
    logic        hit_o;
    logic [31:0] rdata_o;
    logic        tx_o;
    logic        busy_o;

    always #5 clk = ~clk;

    mmio_uart_tx #(
        .WIDTH      (32),
        .BASE_ADDR  (BASE),
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .we_i       (we_i),
        .one_byte_i (one_byte_i),
        .hit_o      (hit_o),
        .rdata_o    (rdata_o),
        .tx_o       (tx_o),
        .busy_o     (busy_o)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: bytes waiting in the FIFO, and the edge on which the current frame ends.
    byte unsigned m_fifo[$];
    bit           m_ovf = 1'b0;
    int           m_frame_end = 0;
    byte unsigned exp_q[$];
    int           start_q[$];
    logic [31:0]  last_rdata;

    function automatic bit model_busy();
        return (cyc < m_frame_end) || (m_fifo.size() > 0);
    endfunction

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        int n;
        n = m_fifo.size();
        s = '0;
        s[0]   = model_busy();
        s[1]   = (n == DEPTH);
        s[2]   = (n == 0);
        s[3]   = m_ovf;
        s[7:4] = (n > 15) ? 4'hF : 4'(n);
        return s;
    endfunction

    // One bus cycle: drive, compare combinational outputs mid-cycle, advance the model.
    task automatic step(input bit we, input bit sb, input logic [31:0] addr, input logic [31:0] data);
        logic        exp_hit;
        logic [31:0] exp_rdata;
        bit          pop;
        bit          try_push;
        bit          full;
        we_i       = we;
        one_byte_i = sb;
        addr_i     = addr;
        wdata_i    = data;
        exp_hit    = (addr >= BASE) && (addr <= BASE + 32'hF);
        exp_rdata  = (exp_hit && (addr - BASE) >= 8 && (addr - BASE) <= 11) ? model_status() : '0;
        @(negedge clk);
        last_rdata = rdata_o;
        check("hit", hit_o, exp_hit);
        check("rdata", rdata_o, exp_rdata);
        check("busy", busy_o, model_busy());
        pop      = (m_fifo.size() > 0) && (cyc + 1 >= m_frame_end);
        try_push = we && sb && (addr == TXD);
        full     = (m_fifo.size() == DEPTH);
        if (try_push && full) m_ovf = 1'b1;
        if (we && exp_hit && (addr - BASE) >= 8 && (addr - BASE) <= 11) m_ovf = 1'b0;
        if (pop) begin
            void'(m_fifo.pop_front());
            start_q.push_back(cyc + 1);
            m_frame_end = cyc + 1 + FRAME;
        end
        if (try_push && !full) begin
            m_fifo.push_back(data[7:0]);
            exp_q.push_back(data[7:0]);
        end
        @(posedge clk);
        #1;
        we_i       = 1'b0;
        one_byte_i = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, STAT, 32'h0);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        we_i  = 1'b0;
        @(posedge clk);
        #1;
        m_fifo.delete();
        exp_q.delete();
        start_q.delete();
        m_ovf       = 1'b0;
        m_frame_end = 0;
        @(negedge clk);
        check("reset_tx", tx_o, 1'b1);
        check("reset_busy", busy_o, 1'b0);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
    endtask

    // Serial monitor: samples tx_o mid-cycle, mid-bit, and checks against the scoreboard.
    initial begin
        int          cnt;
        bit          active;
        bit          bogus;
        byte unsigned cur;
        logic [7:0]  got;
        active = 1'b0;
        bogus  = 1'b0;
        cnt    = 0;
        cur    = 8'h00;
        got    = '0;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                active = 1'b0;
            end else if (!active) begin
                if (tx_o === 1'b0) begin
                    check("frame_expected", (exp_q.size() > 0 && start_q.size() > 0), 1'b1);
                    bogus = !(exp_q.size() > 0 && start_q.size() > 0);
                    if (!bogus) begin
                        cur = exp_q.pop_front();
                        check("start_cycle", cyc, start_q.pop_front());
                    end
                    active = 1'b1;
                    cnt    = 0;
                    got    = '0;
                end
            end else begin
                cnt++;
                if (cnt == 2) check("start_bit", tx_o, 1'b0);
                if (cnt >= 6 && cnt <= 34 && ((cnt - 6) % 4) == 0) got[(cnt - 6) / 4] = tx_o;
                if (cnt == 38) begin
                    check("stop_bit", tx_o, 1'b1);
                    if (!bogus) begin
                        check("byte", got, cur);
                        $display("frame: byte 0x%02h expected 0x%02h", got, cur);
                    end
                    active = 1'b0;
                end
            end
        end
    end

    logic [31:0] addr_tbl [8];

    initial begin
        int guard;
        addr_tbl[0] = TXD;        addr_tbl[1] = TXD;
        addr_tbl[2] = TXD;        addr_tbl[3] = STAT;
        addr_tbl[4] = BASE;       addr_tbl[5] = BASE + 32'hC;
        addr_tbl[6] = BASE + 32'h10;
        addr_tbl[7] = BASE - 32'h4;

        do_reset();
        idle(2);
        check("reset_status", last_rdata, 32'h4);

        // Single byte
        step(1'b1, 1'b1, TXD, 32'h0000_0041);
        idle(45);

        // Two contiguous frames
        step(1'b1, 1'b1, TXD, 32'h0000_0048);
        step(1'b1, 1'b1, TXD, 32'h0000_0069);
        idle(85);

        // Overflow: six stores in consecutive cycles into a 4-deep FIFO
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, TXD, 32'($urandom_range(255)));
        step(1'b0, 1'b0, STAT, 32'h0);
        check("ovf_and_full", last_rdata[3:0] & 4'b1010, 4'b1010);
        step(1'b1, 1'b0, STAT, 32'h0);
        step(1'b0, 1'b0, STAT, 32'h0);
        check("ovf_cleared", last_rdata[3], 1'b0);
        idle(5 * FRAME + 5);

        // Ignored stores: word store to TXDATA, byte store outside the window
        step(1'b1, 1'b0, TXD, 32'h0000_0055);
        step(1'b1, 1'b1, BASE + 32'h10, 32'h0000_0066);
        step(1'b0, 1'b0, STAT, 32'h0);
        check("ignored_no_ovf", last_rdata[3], 1'b0);
        idle(50);

        // Reset in the middle of a frame with bytes still queued
        step(1'b1, 1'b1, TXD, 32'h0000_00A5);
        step(1'b1, 1'b1, TXD, 32'h0000_005A);
        step(1'b1, 1'b1, TXD, 32'h0000_00C3);
        idle(12);
        do_reset();
        step(1'b0, 1'b0, STAT, 32'h0);
        check("post_reset_status", last_rdata, 32'h4);
        idle(60);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            step(($urandom_range(2) == 0), ($urandom_range(3) != 0),
                 addr_tbl[$urandom_range(7)], $urandom);
        end

        guard = 0;
        while ((m_fifo.size() > 0 || cyc < m_frame_end + 2) && guard < 2000) begin
            idle(1);
            guard++;
        end
        check("drain_in_time", (guard < 2000), 1'b1);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
